// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC scan sequencer.
//   - state_e    : scan FSM states
//   - DefDataW   : default ADC result width
//   - DefChW     : default channel index width
//   - AvgSamples : conversions per channel when averaging (ADC_AVG_EN)
//   - AvgShift   : log2(AvgSamples), divides the accumulated sum
package adc_seq_pkg;

  localparam int unsigned DefDataW   = 12;
  localparam int unsigned DefChW     = 2;
  localparam int unsigned AvgSamples = 4;
  localparam int unsigned AvgShift   = 2;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StStart,
    StWait,
    StStore,
    StNext
  } state_e;

endpackage

// File: rtl/adc_period_timer.sv
// Sample-period timer for the ADC scan sequencer.
// Counts 0..PeriodCyc-1 while enable_i is high and pulses tick_o on the
// terminal count, then wraps. enable_i low holds the count at 0.
// Ports:
//   clk_i    : system clock
//   reset_i  : synchronous active-high reset
//   enable_i : counting enabled
//   tick_o   : one-cycle pulse on terminal count
module adc_period_timer #(
  parameter int unsigned PeriodCyc = 1000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int unsigned CntW = (PeriodCyc > 1) ? $clog2(PeriodCyc) : 1;
  localparam logic [CntW-1:0] TermCnt = CntW'(PeriodCyc - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!enable_i) begin
      cnt_d = '0;
    end else if (cnt_q == TermCnt) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = enable_i && (cnt_q == TermCnt);

endmodule

// File: rtl/adc_scan_sequencer.sv
// ADC scan sequencer: on every sample-period tick, walks the enabled channels
// of scan_mask, starts one SPI ADC conversion per channel and forwards each
// result tagged with its channel number.
// Optional feature macro: ADC_AVG_EN -- each channel is converted AvgSamples
// times back-to-back and the truncated mean is forwarded.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   enable              : scanning enabled
//   scan_mask           : bit i set -> channel i converted each scan
//   clr_err             : clears sticky error flags
//   spi_start, spi_ch   : start pulse and channel select to SPI engine
//   spi_busy            : engine busy
//   spi_data_valid/data : conversion result from engine
//   out_valid/data/ch   : tagged result to consumers
//   scan_done           : pulse after the last enabled channel of a scan
//   timeout_err         : sticky, engine failed to answer in time
//   overrun_err         : sticky, period tick arrived mid-scan
module adc_scan_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CH_W        = DefChW,
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned PERIOD_CYC  = 1000,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] scan_mask,
  input  logic              clr_err,
  output logic              spi_start,
  output logic [CH_W-1:0]   spi_ch,
  input  logic              spi_busy,
  input  logic              spi_data_valid,
  input  logic [DATA_W-1:0] spi_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              scan_done,
  output logic              timeout_err,
  output logic              overrun_err
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);
  // One extra bit so the search index can step past the last channel.
  localparam int unsigned IdxW = CH_W + 1;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              timeout_err_q, timeout_err_d;
  logic              overrun_err_q, overrun_err_d;
`ifdef ADC_AVG_EN
  logic [1:0]        smp_q, smp_d;
  logic [DATA_W+1:0] acc_q, acc_d;
`endif

  logic            tick;
  logic            tmo_evt;
  logic            sel_found;
  logic [CH_W-1:0] sel_idx;

  adc_period_timer #(
    .PeriodCyc (PERIOD_CYC)
  ) u_timer (
    .clk_i    (clk),
    .reset_i  (reset),
    .enable_i (enable),
    .tick_o   (tick)
  );

  // Lowest set bit of the latched mask at or above the search index.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (i >= int'(idx_q))) begin
        sel_found = 1'b1;
        sel_idx   = CH_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    idx_d     = idx_q;
    ch_d      = ch_q;
    tmo_d     = tmo_q;
    data_d    = data_q;
`ifdef ADC_AVG_EN
    smp_d     = smp_q;
    acc_d     = acc_q;
`endif
    spi_start = 1'b0;
    out_valid = 1'b0;
    scan_done = 1'b0;
    tmo_evt   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tick && (|scan_mask)) begin
          mask_d  = scan_mask;
          idx_d   = '0;
          state_d = StSelect;
        end
      end
      StSelect: begin
        if (!enable) begin
          // Scan abandoned after the in-flight conversion: no scan_done.
          state_d = StIdle;
        end else if (!sel_found) begin
          scan_done = 1'b1;
          state_d   = StIdle;
        end else begin
          ch_d    = sel_idx;
          idx_d   = {1'b0, sel_idx};
`ifdef ADC_AVG_EN
          smp_d   = '0;
          acc_d   = '0;
`endif
          state_d = StStart;
        end
      end
      StStart: begin
        if (!spi_busy) begin
          spi_start = 1'b1;
          tmo_d     = '0;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (spi_data_valid) begin
`ifdef ADC_AVG_EN
          acc_d = acc_q + {2'b00, spi_data};
          if (smp_q == 2'(AvgSamples - 1)) begin
            data_d  = acc_d[DATA_W+1:AvgShift];
            state_d = StStore;
          end else begin
            smp_d   = smp_q + 1'b1;
            state_d = StStart;
          end
`else
          data_d  = spi_data;
          state_d = StStore;
`endif
        end else if (tmo_q == TmoLast) begin
          // Engine never answered: drop the channel.
          tmo_evt = 1'b1;
          state_d = StNext;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StStore: begin
        out_valid = 1'b1;
        state_d   = StNext;
      end
      StNext: begin
        // Stepping past NUM_CH-1 leaves nothing for SELECT to find.
        idx_d   = idx_q + 1'b1;
        state_d = StSelect;
      end
      default: state_d = StIdle;
    endcase
  end

  // A new error in the same cycle as clr_err keeps the flag set.
  always_comb begin
    timeout_err_d = timeout_err_q;
    overrun_err_d = overrun_err_q;
    if (clr_err) begin
      timeout_err_d = 1'b0;
      overrun_err_d = 1'b0;
    end
    if (tmo_evt) begin
      timeout_err_d = 1'b1;
    end
    if (tick && (state_q != StIdle)) begin
      overrun_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      mask_q        <= '0;
      idx_q         <= '0;
      ch_q          <= '0;
      tmo_q         <= '0;
      data_q        <= '0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef ADC_AVG_EN
      smp_q         <= '0;
      acc_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      idx_q         <= idx_d;
      ch_q          <= ch_d;
      tmo_q         <= tmo_d;
      data_q        <= data_d;
      timeout_err_q <= timeout_err_d;
      overrun_err_q <= overrun_err_d;
`ifdef ADC_AVG_EN
      smp_q         <= smp_d;
      acc_q         <= acc_d;
`endif
    end
  end

  assign spi_ch      = ch_q;
  assign out_data    = data_q;
  assign out_ch      = ch_q;
  assign timeout_err = timeout_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a behavioural SPI engine and a
// scoreboard of expected (channel, data) results.
module tb_adc_scan_sequencer;

  localparam int unsigned NumCh      = 4;
  localparam int unsigned ChW        = 2;
  localparam int unsigned DataW      = 12;
  localparam int unsigned PeriodCyc  = 50;
  localparam int unsigned TimeoutCyc = 15;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic [NumCh-1:0] scan_mask = '0;
  logic             clr_err = 1'b0;
  logic             spi_start;
  logic [ChW-1:0]   spi_ch;
  logic             spi_busy;
  logic             spi_data_valid;
  logic [DataW-1:0] spi_data;
  logic             out_valid;
  logic [DataW-1:0] out_data;
  logic [ChW-1:0]   out_ch;
  logic             scan_done;
  logic             timeout_err;
  logic             overrun_err;

  always #5 clk = ~clk;

  adc_scan_sequencer #(
    .NUM_CH      (NumCh),
    .CH_W        (ChW),
    .DATA_W      (DataW),
    .PERIOD_CYC  (PeriodCyc),
    .TIMEOUT_CYC (TimeoutCyc)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .scan_mask      (scan_mask),
    .clr_err        (clr_err),
    .spi_start      (spi_start),
    .spi_ch         (spi_ch),
    .spi_busy       (spi_busy),
    .spi_data_valid (spi_data_valid),
    .spi_data       (spi_data),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ch         (out_ch),
    .scan_done      (scan_done),
    .timeout_err    (timeout_err),
    .overrun_err    (overrun_err)
  );

  // SPI engine model: data-valid lat cycles after start, value base+ch(+seq).
  int               lat = 5;
  int               drop_ch = -1;
  logic [DataW-1:0] data_base = 12'h100;
  bit               data_inc = 1'b0;
  logic             eng_busy = 1'b0;
  logic             eng_valid = 1'b0;
  logic [DataW-1:0] eng_data = '0;
  logic [DataW-1:0] eng_pend = '0;
  logic [ChW-1:0]   eng_ch = '0;
  int               eng_cnt = 0;
  int               eng_seq = 0;

  assign spi_busy       = eng_busy;
  assign spi_data_valid = eng_valid;
  assign spi_data       = eng_data;

  always @(posedge clk) begin
    eng_valid <= 1'b0;
    if (spi_start) begin
      eng_busy <= 1'b1;
      eng_cnt  <= lat - 1;
      eng_ch   <= spi_ch;
      eng_pend <= data_base + 12'(spi_ch) + (data_inc ? 12'(eng_seq) : 12'd0);
      eng_seq  <= eng_seq + 1;
    end else if (eng_busy) begin
      if (eng_cnt <= 1) begin
        eng_busy <= 1'b0;
        if (int'(eng_ch) != drop_ch) begin
          eng_valid <= 1'b1;
          eng_data  <= eng_pend;
        end
      end
      eng_cnt <= eng_cnt - 1;
    end
  end

  typedef struct {
    logic [ChW-1:0]   ch;
    logic [DataW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   sd_count = 0;
  int   start_count = 0;
  int   last_ov_cyc = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int ch, input int data);
    exp_t e;
    e.ch   = ChW'(ch);
    e.data = DataW'(data);
    exp_q.push_back(e);
  endtask

  // Scoreboard and event monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (out_valid) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_errors++;
        $error("FAIL unexpected_out_valid: observed ch %0d data 0x%0h expected none",
               out_ch, out_data);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_ch", 32'(out_ch), 32'(e.ch));
        check("out_data", 32'(out_data), 32'(e.data));
      end
      last_ov_cyc = cyc;
    end
    if (scan_done) begin
      sd_count++;
      n_checks++;
      assert ((cyc - last_ov_cyc) >= 1 && (cyc - last_ov_cyc) <= 3) else begin
        n_errors++;
        $error("FAIL scan_done_gap: observed %0d cycles expected 1..3", cyc - last_ov_cyc);
      end
    end
    if (spi_start) start_count++;
  end

  task automatic wait_sd(input int target, input int budget);
    int n = 0;
    while (sd_count < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("scan_done_count", 32'(sd_count), 32'(target));
  endtask

  // Returns at the negedge of the cycle in which spi_start for ch is seen.
  task automatic wait_start_ch(input int ch, input int budget);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      if (spi_start && int'(spi_ch) == ch) seen = 1'b1;
      n++;
    end
    check("start_seen", 32'(seen), 32'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_spi_start"}, 32'(spi_start), 32'd0);
    check({tag, "_spi_ch"}, 32'(spi_ch), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_out_ch"}, 32'(out_ch), 32'd0);
    check({tag, "_scan_done"}, 32'(scan_done), 32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    check({tag, "_overrun_err"}, 32'(overrun_err), 32'd0);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
  endtask

  initial begin
    int c_en, t0, t1, sc;
    repeat (3) @(posedge clk);
    #1 check_zero_outputs("reset");
    @(posedge clk); #1 reset = 1'b0;

    // Basic scan, mask 1011, two consecutive periods.
    scan_mask = 4'b1011;
    lat = 5;
    for (int s = 0; s < 2; s++) begin
      push(0, 'h100); push(1, 'h101); push(3, 'h103);
    end
    @(posedge clk); #1 enable = 1'b1;
    c_en = cyc;
    wait_start_ch(0, 100);
    t0 = cyc;
    check("first_start_delay", 32'(t0 - c_en), 32'(PeriodCyc + 1));
    wait_start_ch(0, 100);
    check("scan_period", 32'(cyc - t0), 32'(PeriodCyc));
    wait_sd(2, 100);
    check("basic_queue_empty", 32'(exp_q.size()), 32'd0);
    check("basic_no_overrun", 32'(overrun_err), 32'd0);
    check("basic_no_timeout", 32'(timeout_err), 32'd0);
    #1 enable = 1'b0;

    // Engine silent on ch1: timeout after TimeoutCyc WAIT cycles; clr loses to set.
    drop_ch = 1;
    push(0, 'h100); push(3, 'h103);
    @(posedge clk); #1 enable = 1'b1;
    wait_start_ch(1, 200);
    t1 = cyc;
    repeat (TimeoutCyc) @(posedge clk);
    #1 clr_err = 1'b1;
    check("timeout_not_early", 32'(timeout_err), 32'd0);
    @(posedge clk); #1 clr_err = 1'b0;
    check("timeout_set_beats_clr", 32'(timeout_err), 32'd1);
    check("timeout_cycle", 32'(cyc - t1), 32'(TimeoutCyc + 1));
    wait_sd(3, 100);
    check("timeout_queue_empty", 32'(exp_q.size()), 32'd0);
    #1 enable = 1'b0;
    pulse_clr();
    check("timeout_cleared", 32'(timeout_err), 32'd0);

    // Long engine latency: scan outlasts the period, ticks dropped.
    drop_ch = -1;
    lat = 10;
    scan_mask = 4'b1111;
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 4; c++) push(c, 'h100 + c);
    end
    @(posedge clk); #1 enable = 1'b1;
    wait_sd(4, 200);
    check("overrun_first", 32'(overrun_err), 32'd1);
    wait_sd(5, 200);
    check("overrun_queue_empty", 32'(exp_q.size()), 32'd0);
    #1 enable = 1'b0;
    pulse_clr();
    check("overrun_cleared", 32'(overrun_err), 32'd0);

    // enable drops during ch1 WAIT: ch1 still emitted, no more channels.
    lat = 5;
    push(0, 'h100); push(1, 'h101);
    @(posedge clk); #1 enable = 1'b1;
    wait_start_ch(1, 150);
    @(posedge clk); #1 enable = 1'b0;
    repeat (30) @(posedge clk);
    check("endrop_ch1_emitted", 32'(exp_q.size()), 32'd0);
    check("endrop_no_scan_done", 32'(sd_count), 32'd5);

    // Counter was held at 0: the next scan starts a full period after enable.
    scan_mask = 4'b0001;
    push(0, 'h100);
    @(posedge clk); #1 enable = 1'b1;
    c_en = cyc;
    wait_start_ch(0, 100);
    check("counter_held_at_0", 32'(cyc - c_en), 32'(PeriodCyc + 1));
    wait_sd(6, 50);
    #1 enable = 1'b0;

    // Empty mask: ticks ignored, no conversions, no scan_done.
    scan_mask = 4'b0000;
    sc = start_count;
    @(posedge clk); #1 enable = 1'b1;
    repeat (120) @(posedge clk);
    check("mask0_no_start", 32'(start_count), 32'(sc));
    check("mask0_no_scan_done", 32'(sd_count), 32'd6);
    check("mask0_no_overrun", 32'(overrun_err), 32'd0);
    #1 enable = 1'b0;

    // Reset during WAIT: outputs cleared next cycle, late data-valid ignored.
    scan_mask = 4'b0001;
    @(posedge clk); #1 enable = 1'b1;
    wait_start_ch(0, 100);
    @(posedge clk); #1 reset = 1'b1; enable = 1'b0;
    @(posedge clk); #1 check_zero_outputs("midreset");
    reset = 1'b0;
    sc = start_count;
    repeat (12) @(posedge clk);
    check("midreset_no_restart", 32'(start_count), 32'(sc));
    check("midreset_no_scan_done", 32'(sd_count), 32'd6);

`ifdef ADC_AVG_EN
    // Averaging: samples 10,11,12,13 -> one result of 11.
    data_base = 12'd10;
    data_inc = 1'b1;
    eng_seq = 0;
    sc = start_count;
    push(0, 11);
    @(posedge clk); #1 enable = 1'b1;
    wait_sd(7, 200);
    #1 enable = 1'b0;
    check("avg_four_starts", 32'(start_count - sc), 32'd4);
`endif

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected $finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
